axi_stream_checker: RTL and testbench

//  AXI4-Stream slave sink that consumes the counting stream produced by
//  axi_stream_generator (or passed through neutral_axis_v1_0) and checks it.

---
 rtl/axi_stream_checker_if.sv | 13 +
 rtl/axi_stream_checker.sv | 132 +++++++++++++
 tb/tb_axi_stream_checker.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_checker_if.sv
// AXI4-Stream signal bundle between a stream source and the checker sink.
interface axi_stream_checker_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      tvalid;
    logic                      tready;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tstrb;
    logic                      tlast;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axi_stream_checker.sv
// AXI4-Stream sink that checks a counting stream (data, strobes, framing),
// optionally throttles tready with an LFSR, and reports packet/error counts.
module axi_stream_checker #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    PKT_LEN    = 16,
    parameter logic [DATA_WIDTH-1:0] DATA_SEED  = '0,
    parameter bit                    BP_EN      = 1'b0,
    parameter logic [15:0]           LFSR_SEED  = 16'hACE1
) (
    input  logic                   s_axis_aclk,
    input  logic                   s_axis_areset,
    input  logic                   start,
    input  logic [15:0]            num_pkts,
    axi_stream_checker_if.slave    s_axis,
    output logic [15:0]            pkt_count,
    output logic [15:0]            err_count,
    output logic                   error,
    output logic [DATA_WIDTH-1:0]  first_err_data,
    output logic                   done
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int BEAT_W = $clog2(PKT_LEN + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(PKT_LEN);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t                state, state_nxt;
    logic                  run_start;
    logic                  accept;
    logic                  beat_bad;
    logic                  tready_q;
    logic                  done_q;
    logic [15:0]           lfsr, lfsr_adv;
    logic [15:0]           num_pkts_q;
    logic [DATA_WIDTH-1:0] expected;
    logic [BEAT_W-1:0]     beat;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign lfsr_adv = lfsr_step(lfsr);
    assign accept   = (state == RECV) && tready_q && s_axis.tvalid;
    assign beat_bad = (s_axis.tdata != expected) ||
                      (s_axis.tstrb != {STRB_W{1'b1}}) ||
                      (s_axis.tlast != (beat == LAST_BEAT));

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    run_start = 1'b1;
                    state_nxt = (num_pkts == 16'd0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (accept && s_axis.tlast && (pkt_count + 16'd1 == num_pkts_q)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tready is registered: it reflects LFSR bit 0 (or 1) for the cycle after each edge
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            tready_q       <= 1'b0;
            done_q         <= 1'b0;
            pkt_count      <= '0;
            err_count      <= '0;
            error          <= 1'b0;
            first_err_data <= '0;
            expected       <= DATA_SEED;
            beat           <= '0;
            lfsr           <= LFSR_SEED;
            num_pkts_q     <= '0;
        end else begin
            tready_q <= 1'b0;
            done_q   <= (state_nxt == DONE);
            if (run_start) begin
                pkt_count      <= '0;
                err_count      <= '0;
                error          <= 1'b0;
                first_err_data <= '0;
                expected       <= DATA_SEED;
                beat           <= '0;
                lfsr           <= LFSR_SEED;
                num_pkts_q     <= num_pkts;
                tready_q       <= (state_nxt == RECV) && (BP_EN ? LFSR_SEED[0] : 1'b1);
            end else if (state == RECV) begin
                lfsr     <= lfsr_adv;
                tready_q <= (state_nxt == RECV) && (BP_EN ? lfsr_adv[0] : 1'b1);
                if (accept) begin
                    expected <= expected + DATA_WIDTH'(1);
                    // framing resyncs on whatever tlast arrives, early or late
                    if (s_axis.tlast) begin
                        beat      <= '0;
                        pkt_count <= pkt_count + 16'd1;
                    end else if (beat != BEAT_MAX) begin
                        beat <= beat + BEAT_W'(1);
                    end
                    if (beat_bad) begin
                        err_count <= sat_inc(err_count);
                        error     <= 1'b1;
                        if (!error) begin
                            first_err_data <= s_axis.tdata;
                        end
                    end
                end
            end
        end
    end

    assign s_axis.tready = tready_q;
    assign done          = done_q;
endmodule

// File: tb/tb_axi_stream_checker.sv
// Directed bench for axi_stream_checker: one instance without and one with backpressure.
module tb_axi_stream_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, start1;
    logic [15:0] num0, num1;
    logic [15:0] pkt0, err0, pkt1, err1;
    logic        error0, error1, done0, done1;
    logic [31:0] fed0, fed1;

    axi_stream_checker_if #(.DATA_WIDTH(32)) ax0 ();
    axi_stream_checker_if #(.DATA_WIDTH(32)) ax1 ();

    axi_stream_checker #(.DATA_WIDTH(32), .PKT_LEN(16), .DATA_SEED(32'd0), .BP_EN(1'b0)) u_dut0 (
        .s_axis_aclk(clk), .s_axis_areset(rst), .start(start0), .num_pkts(num0),
        .s_axis(ax0), .pkt_count(pkt0), .err_count(err0), .error(error0),
        .first_err_data(fed0), .done(done0));

    axi_stream_checker #(.DATA_WIDTH(32), .PKT_LEN(16), .DATA_SEED(32'd0), .BP_EN(1'b1)) u_dut1 (
        .s_axis_aclk(clk), .s_axis_areset(rst), .start(start1), .num_pkts(num1),
        .s_axis(ax1), .pkt_count(pkt1), .err_count(err1), .error(error1),
        .first_err_data(fed1), .done(done1));

    typedef struct {
        logic [31:0] tdata;
        logic [3:0]  tstrb;
        logic        tlast;
        logic [15:0] pkt;
        logic [15:0] err;
        logic        error;
    } vec_t;

    vec_t vq[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic [3:0] s, input logic l,
                                input int p, input int e, input logic er);
        vec_t v;
        v.tdata = d; v.tstrb = s; v.tlast = l;
        v.pkt = 16'(p); v.err = 16'(e); v.error = er;
        return v;
    endfunction

    // Called at a negedge; leaves the bench at a negedge.
    task automatic start_run0(input logic [15:0] n, input string tag);
        start0 = 1'b1; num0 = n;
        @(negedge clk);
        start0 = 1'b0;
        check({tag, ".tready_on"}, ax0.tready, 1);
        check({tag, ".err_clr"}, err0, 0);
        check({tag, ".pkt_clr"}, pkt0, 0);
    endtask

    task automatic apply(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            ax0.tvalid = 1'b1;
            ax0.tdata  = vq[i].tdata;
            ax0.tstrb  = vq[i].tstrb;
            ax0.tlast  = vq[i].tlast;
            @(negedge clk);
            check($sformatf("%s[%0d].pkt", tag, i - lo), pkt0, vq[i].pkt);
            check($sformatf("%s[%0d].err", tag, i - lo), err0, vq[i].err);
            check($sformatf("%s[%0d].error", tag, i - lo), error0, vq[i].error);
        end
        ax0.tvalid = 1'b0;
        ax0.tlast  = 1'b0;
    endtask

    task automatic feed_clean0(input int n);
        for (int i = 0; i < n; i++) begin
            ax0.tvalid = 1'b1; ax0.tdata = 32'(i); ax0.tstrb = 4'hF; ax0.tlast = (i % 16 == 15);
            @(negedge clk);
        end
        ax0.tvalid = 1'b0; ax0.tlast = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        int k, cyc, stalls;

        // T1: 0..31, tlast on 15/31
        for (int i = 0; i < 32; i++)
            vq.push_back(mk(32'(i), 4'hF, (i == 15 || i == 31), (i >= 15) + (i >= 31), 0, 1'b0));
        // T3: bad data on beat 5, one packet
        for (int i = 0; i < 16; i++)
            vq.push_back(mk((i == 5) ? 32'hDEAD_BEEF : 32'(i), 4'hF, (i == 15), (i == 15),
                            (i >= 5), (i >= 5)));
        // T4: early tlast on beat 10, then one good packet with a bad strobe at data 20
        for (int i = 0; i <= 10; i++)
            vq.push_back(mk(32'(i), 4'hF, (i == 10), (i == 10), (i == 10), (i == 10)));
        for (int i = 11; i <= 26; i++)
            vq.push_back(mk(32'(i), (i == 20) ? 4'h7 : 4'hF, (i == 26), 1 + (i == 26),
                            1 + (i >= 20), 1'b1));

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; num0 = '0; num1 = '0;
        ax0.tvalid = 1'b0; ax0.tdata = '0; ax0.tstrb = '0; ax0.tlast = 1'b0;
        ax1.tvalid = 1'b0; ax1.tdata = '0; ax1.tstrb = '0; ax1.tlast = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.tready", ax0.tready, 0);
        check("rst.pkt", pkt0, 0);
        check("rst.err", err0, 0);
        check("rst.error", error0, 0);
        check("rst.fed", fed0, 0);
        check("rst.done", done0, 0);
        rst = 1'b0;
        @(negedge clk);

        // T1
        start_run0(16'd2, "t1");
        apply(0, 31, "t1");
        check("t1.done", done0, 1);
        check("t1.tready_off", ax0.tready, 0);
        ax0.tvalid = 1'b1; ax0.tdata = 32'h1234; ax0.tstrb = 4'h0;
        @(negedge clk);
        ax0.tvalid = 1'b0;
        check("t1.idle_valid_err", err0, 0);
        check("t1.idle_valid_pkt", pkt0, 2);

        // T2: backpressured instance, source holds data while tready is low
        start1 = 1'b1; num1 = 16'd2;
        @(negedge clk);
        start1 = 1'b0;
        k = 0; cyc = 0; stalls = 0;
        while (k < 32 && cyc < 1000) begin
            ax1.tvalid = 1'b1; ax1.tdata = 32'(k); ax1.tstrb = 4'hF;
            ax1.tlast = (k == 15 || k == 31);
            if (ax1.tready) k++;
            else stalls++;
            @(negedge clk);
            cyc++;
        end
        ax1.tvalid = 1'b0; ax1.tlast = 1'b0;
        check("t2.budget", (cyc < 1000), 1);
        check("t2.stalled", (stalls > 0), 1);
        check("t2.pkt", pkt1, 2);
        check("t2.err", err1, 0);
        check("t2.error", error1, 0);
        check("t2.done", done1, 1);
        check("t2.tready_off", ax1.tready, 0);

        // T3
        start_run0(16'd1, "t3");
        apply(32, 47, "t3");
        check("t3.fed", fed0, 32'hDEAD_BEEF);
        check("t3.done", done0, 1);

        // T4
        start_run0(16'd2, "t4");
        apply(48, 74, "t4");
        check("t4.fed", fed0, 32'd10);
        check("t4.done", done0, 1);

        // T5: async reset while beat 8 is on the bus, then a clean run
        start_run0(16'd1, "t5");
        for (int i = 0; i < 8; i++) begin
            ax0.tvalid = 1'b1; ax0.tdata = (i == 3) ? 32'h55 : 32'(i); ax0.tstrb = 4'hF;
            ax0.tlast = 1'b0;
            @(negedge clk);
        end
        check("t5.pre_err", err0, 1);
        check("t5.pre_fed", fed0, 32'h55);
        ax0.tdata = 32'd8;
        #2 rst = 1'b1;
        #1;
        check("t5.rst_err", err0, 0);
        check("t5.rst_error", error0, 0);
        check("t5.rst_fed", fed0, 0);
        check("t5.rst_tready", ax0.tready, 0);
        @(negedge clk);
        rst = 1'b0; ax0.tvalid = 1'b0;
        check("t5.rst_done", done0, 0);
        check("t5.rst_pkt", pkt0, 0);
        start_run0(16'd1, "t5b");
        feed_clean0(16);
        check("t5.clean_err", err0, 0);
        check("t5.clean_pkt", pkt0, 1);
        check("t5.clean_done", done0, 1);

        // T6: zero packets from IDLE
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start0 = 1'b1; num0 = 16'd0;
        @(negedge clk);
        start0 = 1'b0;
        check("t6.done", done0, 1);
        ax0.tvalid = 1'b1; ax0.tdata = 32'h99; ax0.tstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t6.tready[%0d]", i), ax0.tready, 0);
            @(negedge clk);
        end
        ax0.tvalid = 1'b0;
        check("t6.err", err0, 0);
        check("t6.pkt", pkt0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
